// File: rtl/mux_arb_rr.sv
// Round-robin N:1 arbiter/mux with a one-word registered output stage.
// Optional MUX_ARB_RR_FORCE_EN adds force_en/force_ch to pin the grant to one channel.
module mux_arb_rr #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_ARB_RR_FORCE_EN
  ,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_ch
`endif
);

  if ((1 << SEL_W) < CHANNELS || CHANNELS < 2 || CHANNELS > 16) begin : g_param_check
    $error("mux_arb_rr: need 2 <= CHANNELS <= 16 and 2**SEL_W >= CHANNELS");
  end

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_data,  w_data_nxt;
  logic [SEL_W-1:0]   r_ch,    w_ch_nxt;
  logic [SEL_W-1:0]   r_ptr,   w_ptr_nxt;

  logic               w_load;
  logic               w_found;
  logic [SEL_W-1:0]   w_grant;
  logic [WIDTH-1:0]   w_sel;

  assign w_load = (r_state == S_EMPTY) || out_ready;

  // Scan offsets from high to low so the lowest offset from r_ptr wins.
  always_comb begin : arbitrate
    w_found = 1'b0;
    w_grant = '0;
`ifdef MUX_ARB_RR_FORCE_EN
    if (force_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (force_ch == SEL_W'(i) && in_valid[i]) begin
          w_found = 1'b1;
          w_grant = SEL_W'(i);
        end
      end
    end else begin
`endif
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (i == (int'(r_ptr) + k) % CHANNELS && in_valid[i]) begin
            w_found = 1'b1;
            w_grant = SEL_W'(i);
          end
        end
      end
`ifdef MUX_ARB_RR_FORCE_EN
    end
`endif
  end

  always_comb begin : select
    w_sel    = '0;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_sel       = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !reset && w_load && w_found;
      end
    end
  end

  always_comb begin : next_state
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_ch_nxt    = r_ch;
    w_ptr_nxt   = r_ptr;
    if (w_load) begin
      if (w_found) begin
        w_state_nxt = S_FULL;
        w_data_nxt  = w_sel;
        w_ch_nxt    = w_grant;
`ifdef MUX_ARB_RR_FORCE_EN
        if (!force_en) begin
`endif
          if (int'(w_grant) == CHANNELS - 1) w_ptr_nxt = '0;
          else                               w_ptr_nxt = w_grant + SEL_W'(1);
`ifdef MUX_ARB_RR_FORCE_EN
        end
`endif
      end else begin
        w_state_nxt = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_ch    <= w_ch_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: directed scenarios on a 2-channel and a 4-channel instance,
// plus randomized traffic against a distance-based round-robin model and scoreboard.
module tb_mux_arb_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [9:0]  d2_in_data;
  logic [1:0]  d2_in_valid, d2_in_ready;
  logic [4:0]  d2_out_data;
  logic        d2_out_ch, d2_out_valid, d2_out_ready;

  logic [31:0] d4_in_data;
  logic [3:0]  d4_in_valid, d4_in_ready;
  logic [7:0]  d4_out_data;
  logic [1:0]  d4_out_ch;
  logic        d4_out_valid, d4_out_ready;

`ifdef MUX_ARB_RR_FORCE_EN
  logic        d2_force_en, d4_force_en;
  logic        d2_force_ch;
  logic [1:0]  d4_force_ch;
`endif

  int total = 0;
  int bad   = 0;

  mux_arb_rr #(.WIDTH(5), .CHANNELS(2), .SEL_W(1)) dut2 (
    .clk(clk), .reset(reset),
    .in_data(d2_in_data), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .out_data(d2_out_data), .out_ch(d2_out_ch), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready)
`ifdef MUX_ARB_RR_FORCE_EN
    , .force_en(d2_force_en), .force_ch(d2_force_ch)
`endif
  );

  mux_arb_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
    .clk(clk), .reset(reset),
    .in_data(d4_in_data), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .out_data(d4_out_data), .out_ch(d4_out_ch), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready)
`ifdef MUX_ARB_RR_FORCE_EN
    , .force_en(d4_force_en), .force_ch(d4_force_ch)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    d2_in_data = 10'h3FF; d2_in_valid = 2'b11; d2_out_ready = 1'b1;
    d4_in_data = 32'hFFFF_FFFF; d4_in_valid = 4'hF; d4_out_ready = 1'b1;
`ifdef MUX_ARB_RR_FORCE_EN
    d2_force_en = 1'b0; d2_force_ch = 1'b0; d4_force_en = 1'b0; d4_force_ch = 2'd0;
`endif
    #2;
    total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL rst_d2_valid got=%b want=0", d2_out_valid); end
    total++; if (d2_out_data !== 5'h00) begin bad++; $display("FAIL rst_d2_data got=%h want=00", d2_out_data); end
    total++; if (d2_out_ch !== 1'b0) begin bad++; $display("FAIL rst_d2_ch got=%b want=0", d2_out_ch); end
    total++; if (d2_in_ready !== 2'b00) begin bad++; $display("FAIL rst_d2_ready got=%b want=00", d2_in_ready); end
    total++; if (d4_out_valid !== 1'b0) begin bad++; $display("FAIL rst_d4_valid got=%b want=0", d4_out_valid); end
    total++; if (d4_in_ready !== 4'b0000) begin bad++; $display("FAIL rst_d4_ready got=%b want=0000", d4_in_ready); end
    tick();
    total++; if (d4_out_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b want=0", d4_out_valid); end
    total++; if (d4_out_data !== 8'h00) begin bad++; $display("FAIL rst_hold_data got=%h want=00", d4_out_data); end
    total++; if (d4_in_ready !== 4'b0000) begin bad++; $display("FAIL rst_hold_ready got=%b want=0000", d4_in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_alternate;
    logic       exp_ch;
    logic [4:0] exp_data;
    logic [1:0] exp_rdy;
    d2_in_data = {5'h15, 5'h0A}; d2_in_valid = 2'b11; d2_out_ready = 1'b1;
    #1;
    total++; if (d2_in_ready !== 2'b01) begin bad++; $display("FAIL alt_first_ready got=%b want=01", d2_in_ready); end
    total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL alt_pre_valid got=%b want=0", d2_out_valid); end
    for (int n = 0; n < 6; n++) begin
      tick();
      exp_ch   = 1'(n % 2);
      exp_data = exp_ch ? 5'h15 : 5'h0A;
      exp_rdy  = exp_ch ? 2'b01 : 2'b10;
      total++; if (d2_out_valid !== 1'b1) begin bad++; $display("FAIL alt_valid n=%0d got=%b want=1", n, d2_out_valid); end
      total++; if (d2_out_data !== exp_data) begin bad++; $display("FAIL alt_data n=%0d got=%h want=%h", n, d2_out_data, exp_data); end
      total++; if (d2_out_ch !== exp_ch) begin bad++; $display("FAIL alt_ch n=%0d got=%b want=%b", n, d2_out_ch, exp_ch); end
      total++; if (d2_in_ready !== exp_rdy) begin bad++; $display("FAIL alt_ready n=%0d got=%b want=%b", n, d2_in_ready, exp_rdy); end
    end
  endtask

  task automatic test_stall;
    pulse_reset();
    d2_in_data = {5'h15, 5'h0A}; d2_in_valid = 2'b01; d2_out_ready = 1'b1;
    tick();
    total++; if (d2_out_data !== 5'h0A) begin bad++; $display("FAIL stall_setup_data got=%h want=0a", d2_out_data); end
    d2_in_valid = 2'b10; d2_out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      total++; if (d2_in_ready !== 2'b00) begin bad++; $display("FAIL stall_ready n=%0d got=%b want=00", n, d2_in_ready); end
      total++; if (d2_out_data !== 5'h0A) begin bad++; $display("FAIL stall_data n=%0d got=%h want=0a", n, d2_out_data); end
      total++; if (d2_out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid n=%0d got=%b want=1", n, d2_out_valid); end
      tick();
    end
    d2_out_ready = 1'b1;
    #1;
    total++; if (d2_in_ready !== 2'b10) begin bad++; $display("FAIL unstall_ready got=%b want=10", d2_in_ready); end
    tick();
    total++; if (d2_out_data !== 5'h15) begin bad++; $display("FAIL unstall_data got=%h want=15", d2_out_data); end
    total++; if (d2_out_ch !== 1'b1) begin bad++; $display("FAIL unstall_ch got=%b want=1", d2_out_ch); end
  endtask

  task automatic test_wrap;
    pulse_reset();
    d4_in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; d4_in_valid = 4'b1000; d4_out_ready = 1'b1;
    #1;
    total++; if (d4_in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3 got=%b want=1000", d4_in_ready); end
    tick();
    total++; if (d4_out_ch !== 2'd3) begin bad++; $display("FAIL wrap_ch3 got=%0d want=3", d4_out_ch); end
    total++; if (d4_out_data !== 8'hD3) begin bad++; $display("FAIL wrap_data3 got=%h want=d3", d4_out_data); end
    d4_in_valid = 4'b0001;
    #1;
    total++; if (d4_in_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0 got=%b want=0001", d4_in_ready); end
    tick();
    total++; if (d4_out_ch !== 2'd0) begin bad++; $display("FAIL wrap_ch0 got=%0d want=0", d4_out_ch); end
    total++; if (d4_out_data !== 8'hA0) begin bad++; $display("FAIL wrap_data0 got=%h want=a0", d4_out_data); end
    d4_in_valid = 4'b0000;
    #1;
    total++; if (d4_in_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b want=0000", d4_in_ready); end
    tick();
    total++; if (d4_out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", d4_out_valid); end
    total++; if (d4_out_data !== 8'hA0) begin bad++; $display("FAIL idle_hold_data got=%h want=a0", d4_out_data); end
    total++; if (d4_out_ch !== 2'd0) begin bad++; $display("FAIL idle_hold_ch got=%0d want=0", d4_out_ch); end
  endtask

  task automatic test_reset_mid;
    pulse_reset();
    d4_in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; d4_in_valid = 4'b0100; d4_out_ready = 1'b1;
    tick();
    total++; if (d4_out_ch !== 2'd2) begin bad++; $display("FAIL mid_setup_ch got=%0d want=2", d4_out_ch); end
    d4_out_ready = 1'b0; d4_in_valid = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    total++; if (d4_out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", d4_out_valid); end
    total++; if (d4_out_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h want=00", d4_out_data); end
    reset = 1'b0;
    d4_in_valid = 4'b1111; d4_out_ready = 1'b1;
    #1;
    total++; if (d4_in_ready !== 4'b0001) begin bad++; $display("FAIL mid_rel_ready got=%b want=0001", d4_in_ready); end
    tick();
    total++; if (d4_out_ch !== 2'd0) begin bad++; $display("FAIL mid_rel_ch got=%0d want=0", d4_out_ch); end
    total++; if (d4_out_data !== 8'hA0) begin bad++; $display("FAIL mid_rel_data got=%h want=a0", d4_out_data); end
  endtask

`ifdef MUX_ARB_RR_FORCE_EN
  task automatic test_force;
    pulse_reset();
    d2_force_en = 1'b0; d2_in_data = {5'h15, 5'h0A}; d2_in_valid = 2'b01; d2_out_ready = 1'b1;
    tick();
    d2_force_en = 1'b1; d2_force_ch = 1'b1; d2_in_valid = 2'b01;
    #1;
    total++; if (d2_in_ready !== 2'b00) begin bad++; $display("FAIL force_nogrant_ready got=%b want=00", d2_in_ready); end
    tick();
    total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL force_nogrant_valid got=%b want=0", d2_out_valid); end
    d2_in_valid = 2'b11;
    #1;
    total++; if (d2_in_ready !== 2'b10) begin bad++; $display("FAIL force_grant_ready got=%b want=10", d2_in_ready); end
    tick();
    total++; if (d2_out_ch !== 1'b1) begin bad++; $display("FAIL force_grant_ch got=%b want=1", d2_out_ch); end
    total++; if (d2_out_data !== 5'h15) begin bad++; $display("FAIL force_grant_data got=%h want=15", d2_out_data); end
    d2_force_en = 1'b0;
    #1;
    total++; if (d2_in_ready !== 2'b10) begin bad++; $display("FAIL force_ptr_kept got=%b want=10", d2_in_ready); end
    tick();
  endtask
`endif

  task automatic test_random;
    int          m_valid, m_ch, m_ptr;
    logic [7:0]  m_data;
    int          wt[4];
    logic [9:0]  sb[$];
    logic [9:0]  w;
    int          g, best, load;
    logic [3:0]  exp_rdy;
    pulse_reset();
    m_valid = 0; m_ch = 0; m_ptr = 0; m_data = 8'h00;
    for (int c = 0; c < 4; c++) wt[c] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < 4; c++) d4_in_valid[c] = ($urandom_range(0, 9) < 7);
      d4_in_data   = $urandom();
      d4_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      load = (m_valid == 0 || d4_out_ready) ? 1 : 0;
      g = -1; best = 99;
      for (int c = 0; c < 4; c++)
        if (d4_in_valid[c] && ((c - m_ptr + 4) % 4) < best) begin best = (c - m_ptr + 4) % 4; g = c; end
      exp_rdy = (load != 0 && g >= 0) ? (4'b0001 << g) : 4'b0000;
      total++; if (d4_in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, d4_in_ready, exp_rdy); end
      total++; if (!$onehot0(d4_in_ready)) begin bad++; $display("FAIL rnd_onehot cyc=%0d got=%b want=onehot0", cyc, d4_in_ready); end
      total++; if (d4_out_valid !== 1'(m_valid)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%0d", cyc, d4_out_valid, m_valid); end
      total++; if (d4_out_data !== m_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, d4_out_data, m_data); end
      total++; if (d4_out_ch !== 2'(m_ch)) begin bad++; $display("FAIL rnd_ch cyc=%0d got=%0d want=%0d", cyc, d4_out_ch, m_ch); end
      if (d4_out_valid === 1'b1 && d4_out_ready) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rnd_dup cyc=%0d got=%h want=none", cyc, {d4_out_ch, d4_out_data}); end
        else begin
          w = sb.pop_front();
          if ({d4_out_ch, d4_out_data} !== w) begin bad++; $display("FAIL rnd_sb cyc=%0d got=%h want=%h", cyc, {d4_out_ch, d4_out_data}, w); end
        end
      end
      for (int c = 0; c < 4; c++) if (!d4_in_valid[c]) wt[c] = 0;
      if (load != 0 && g >= 0) begin
        sb.push_back({2'(g), d4_in_data[g*8 +: 8]});
        for (int c = 0; c < 4; c++) if (c != g && d4_in_valid[c]) wt[c]++;
        wt[g] = 0;
        best = 0;
        for (int c = 0; c < 4; c++) if (wt[c] > best) best = wt[c];
        total++; if (best > 3) begin bad++; $display("FAIL rnd_starve cyc=%0d got=%0d want<=3", cyc, best); end
        m_valid = 1; m_data = d4_in_data[g*8 +: 8]; m_ch = g; m_ptr = (g + 1) % 4;
      end else if (load != 0) begin
        m_valid = 0;
      end
      tick();
    end
    total++; if (sb.size() != m_valid) begin bad++; $display("FAIL rnd_lost got=%0d want=%0d", sb.size(), m_valid); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef MUX_ARB_RR_FORCE_EN
    test_force();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arb_rr.md
MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 Parameter WIDTH, default 5: data bits per channel.
REQ-002 Parameter CHANNELS, default 2: number of input channels, range 2..16.
REQ-003 Parameter SEL_W, default 1: channel-index width; the block SHALL require 2**SEL_W >= CHANNELS.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 in_data  input  CHANNELS*WIDTH: channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 in_valid  input  CHANNELS: per-channel valid.
REQ-008 in_ready  output  CHANNELS: per-channel accept, combinational, at most one bit high.
REQ-009 out_data  output  WIDTH: registered selected word.
REQ-010 out_ch  output  SEL_W: registered index of the channel that supplied out_data.
REQ-011 out_valid  output  1: output register holds a word.
REQ-012 out_ready  input  1: downstream accepts the word this cycle.

Function
REQ-013 The block SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 load = !out_valid | out_ready; arbitration SHALL occur only in cycles where load=1.
REQ-015 When load=1 and in_valid!=0, grant SHALL be the first valid channel found scanning upward from ptr, wrapping from CHANNELS-1 to 0.
REQ-016 in_ready[grant] SHALL be 1 in that cycle and all other in_ready bits SHALL be 0; when load=0 or no grant, all in_ready bits SHALL be 0.
REQ-017 On a grant, next edge: out_data<=in_data[grant], out_ch<=grant, out_valid<=1, ptr<=grant+1, with CHANNELS wrapping to 0.
REQ-018 When load=1 and no grant, next edge: out_valid<=0; out_data, out_ch and ptr SHALL hold.
REQ-019 When load=0 (FULL, out_ready=0), all registers SHALL hold; the input is stalled.
REQ-020 Latency SHALL be one cycle from the in_valid&in_ready edge to out_valid; throughput SHALL be one word per cycle with out_ready held high.
REQ-021 FULL with out_ready=1 and a new grant SHALL replace the word in the same edge with no bubble.
REQ-022 A channel SHALL wait at most CHANNELS-1 grants to other channels while it holds in_valid=1.
REQ-023 Input data SHALL pass unmodified; no width conversion.

Reset
REQ-024 While reset=1: out_valid=0, out_data=0, out_ch=0, ptr=0, all in_ready=0, independent of clk.
REQ-025 Reset asserted mid-transfer SHALL discard the held word; the first grant after release SHALL scan from channel 0.

Configuration
REQ-026 Macro MUX_ARB_RR_FORCE_EN defined: the block SHALL add inputs force_en (1 bit) and force_ch (SEL_W bits).
REQ-027 With the macro defined and force_en=1, grant SHALL be force_ch only if in_valid[force_ch]=1 and force_ch<CHANNELS; otherwise there SHALL be no grant. ptr SHALL NOT change on forced grants.
REQ-028 With the macro defined and force_en=0, or with the macro undefined, the block SHALL arbitrate round-robin only; when undefined, force_en and force_ch SHALL NOT exist.

Verification
REQ-029 Reset, then CHANNELS=2 with in_valid=2'b11, data 5'h0A/5'h15 held, out_ready=1 -> out_data alternates 0A,15,0A,... with out_ch 0,1,0; out_valid is first 1 one cycle after the first grant.
REQ-030 FULL with word 0A, out_ready=0 for 3 cycles, in_valid=2'b10 -> in_ready=0, out_data stays 0A; with out_ready=1 -> next edge gives out_data=15, out_ch=1.
REQ-031 CHANNELS=4, WIDTH=8, only ch3 valid with ptr=0 -> grant ch3, ptr wraps to 0; then only ch0 valid -> immediate grant.
REQ-032 Assert reset while FULL with out_ready=0 -> out_valid=0 before the next clk edge; after release, all channels valid -> first out_ch=0.
REQ-033 MUX_ARB_RR_FORCE_EN defined, force_en=1, force_ch=1, in_valid=2'b01 -> no grant, out_valid falls; then in_valid=2'b11 -> out_ch=1 and ptr unchanged.
REQ-034 Random valid/ready traffic for 10k cycles -> no word lost or duplicated, no channel starved more than CHANNELS-1 grants, in_ready one-hot or zero.
